// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: FSM state enum, default width constants and pointer-width helper shared by mem_arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int NREQ_DEF = 4;
  localparam int AW_DEF = 64;
  localparam int DW_DEF = 64;
  localparam int TIMEOUT_DEF = 255;
  function automatic int ptr_w(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester bus (u_req/u_wr/u_addr/u_wdata -> u_rdata/u_rdy/u_err) plus memory bus (m_req/m_wr/m_addr/m_wdata <- m_rdata/m_rdy); slave = arbiter, master = requesters and memory
interface mem_arbiter_if import mem_arbiter_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic [NREQ-1:0] u_req, u_wr, u_rdy;
  logic [NREQ*AW-1:0] u_addr;
  logic [NREQ*DW-1:0] u_wdata;
  logic [DW-1:0] u_rdata, m_wdata, m_rdata;
  logic [AW-1:0] m_addr;
  logic u_err, m_req, m_wr, m_rdy;
  modport slave(
    input u_req, u_wr, u_addr, u_wdata, m_rdata, m_rdy,
    output u_rdata, u_rdy, u_err, m_req, m_wr, m_addr, m_wdata
  );
  modport master(
    output u_req, u_wr, u_addr, u_wdata, m_rdata, m_rdy,
    input u_rdata, u_rdy, u_err, m_req, m_wr, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; ports req (request vector), last (previous grant) in, gnt (one-hot), idx, vld out
module rr_pick import mem_arbiter_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  localparam int PW = ptr_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            vld
);
  logic [PW-1:0] j;
  always_comb begin
    idx = '0;
    j = '0;
    for (int i = NREQ; i >= 1; i--) begin
      j = PW'((int'(last) + i) % NREQ);
      idx = req[j] ? j : idx;
    end
    vld = |req;
    gnt = vld ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin NREQ-to-one memory port arbiter with timeout watchdog; ports clk, rst (async active-low), bus (mem_arbiter_if.slave); MEM_ARBITER_RMW_LOCK_EN adds a read-modify-write lock
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.slave bus
);
  localparam int PW = ptr_w(NREQ);
  localparam int CW = ptr_w(TIMEOUT + 1);
  state_t state;
  logic [PW-1:0] last, pidx;
  logic [NREQ-1:0] req_ok, pgnt, gnt;
  logic pvld, tmo;
  logic [CW-1:0] cnt;
  assign tmo = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
`ifdef MEM_ARBITER_RMW_LOCK_EN
  logic lock;
  logic [PW-1:0] owner;
  assign req_ok = lock ? bus.u_req & (NREQ'(1) << owner) : bus.u_req;
`else
  assign req_ok = bus.u_req;
`endif
  rr_pick #(.NREQ(NREQ)) u_pick (.req(req_ok), .last(last), .gnt(pgnt), .idx(pidx), .vld(pvld));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      last <= PW'(NREQ - 1);
      gnt <= '0;
      cnt <= '0;
      bus.m_req <= 1'b0;
      bus.m_wr <= 1'b0;
      bus.m_addr <= '0;
      bus.m_wdata <= '0;
      bus.u_rdy <= '0;
      bus.u_err <= 1'b0;
      bus.u_rdata <= '0;
`ifdef MEM_ARBITER_RMW_LOCK_EN
      lock <= 1'b0;
      owner <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          bus.u_err <= 1'b0;
          if (pvld) begin
            state <= BUSY;
            gnt <= pgnt;
            last <= pidx;
            bus.m_req <= 1'b1;
            bus.m_wr <= bus.u_wr[pidx];
            bus.m_addr <= bus.u_addr[pidx*AW +: AW];
            bus.m_wdata <= bus.u_wdata[pidx*DW +: DW];
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (bus.m_rdy || tmo) begin
            state <= DONE;
            bus.m_req <= 1'b0;
            bus.u_rdy <= gnt;
            bus.u_err <= !bus.m_rdy;
            bus.u_rdata <= (bus.m_rdy && !bus.m_wr) ? bus.m_rdata : '0;
`ifdef MEM_ARBITER_RMW_LOCK_EN
            if (!bus.m_rdy) lock <= 1'b0;
            else if (!bus.m_wr) begin
              lock <= 1'b1;
              owner <= last;
            end else if (last == owner) lock <= 1'b0;
`endif
          end
        end
        default: begin
          state <= IDLE;
          bus.u_rdy <= '0;
          bus.u_err <= 1'b0;
          bus.u_rdata <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table vectors, hand sequences and randomized batches checked against a round-robin reference model
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  localparam int NREQ = 4;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TO = 8;
  localparam logic [63:0] K = 64'h0123_4567_89AB_CDEF;
  typedef struct {int idx; logic [DW-1:0] rdata; logic err; int cyc;} cpl_t;
  typedef struct {logic [AW-1:0] addr; logic wr; logic [DW-1:0] wdata; int lat;} mtx_t;
  typedef struct {int idx; logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; int lat; logic [DW-1:0] rdata; logic err;} vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  mem_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus();
  mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut(.clk(clk), .rst(rst), .bus(bus));
  cpl_t cq[$];
  mtx_t mq[$];
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] shadow [logic [AW-1:0]];
  logic [NREQ-1:0] last_drop = '0;
  int busy_cnt = 0, cur_lat = 0, fix_lat = 0, cyc = 0, ref_last = NREQ - 1;
  bit rand_lat = 0, spur = 0, rereq = 0, scramble = 0;
  int n_cmp = 0, n_bad = 0;

  function automatic logic [DW-1:0] rd_init(input logic [AW-1:0] a);
    return a ^ K;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.m_req) begin
      busy_cnt++;
      if (busy_cnt == 1) begin
        cur_lat = rand_lat ? int'($urandom_range(0, 9)) : fix_lat;
        mq.push_back('{bus.m_addr, bus.m_wr, bus.m_wdata, cur_lat});
        if (scramble) begin
          bus.u_addr = ~bus.u_addr;
          bus.u_wdata = ~bus.u_wdata;
          bus.u_wr = ~bus.u_wr;
        end
      end else if (mq.size() > 0) begin
        chk("m_addr_stable", bus.m_addr, mq[$].addr);
        chk("m_wr_stable", 64'(bus.m_wr), 64'(mq[$].wr));
        chk("m_wdata_stable", bus.m_wdata, mq[$].wdata);
      end
      bus.m_rdy = (busy_cnt == cur_lat + 1);
      bus.m_rdata = '0;
      if (bus.m_rdy) begin
        if (bus.m_wr) mem[bus.m_addr] = bus.m_wdata;
        else bus.m_rdata = mem.exists(bus.m_addr) ? mem[bus.m_addr] : rd_init(bus.m_addr);
      end
    end else begin
      busy_cnt = 0;
      bus.m_rdy = spur;
      bus.m_rdata = spur ? '1 : '0;
    end
    if (|bus.u_rdy) begin
      chk("u_rdy_onehot", 64'($countones(bus.u_rdy)), 64'd1);
      for (int i = 0; i < NREQ; i++)
        if (bus.u_rdy[i]) cq.push_back('{i, bus.u_rdata, bus.u_err, cyc});
    end else chk("u_err_without_rdy", 64'(bus.u_err), 64'd0);
    bus.u_req = (bus.u_req & ~bus.u_rdy) | (rereq ? last_drop : '0);
    last_drop = bus.u_rdy;
  endtask

  task automatic wait_cpl(input int n, input int bound);
    int t = 0;
    while (cq.size() < n && t < bound) begin
      tick();
      t++;
    end
    if (cq.size() < n) chk("completion_wait_expired", 64'(cq.size()), 64'(n));
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.u_wr[i] = wr;
    bus.u_addr[i*AW +: AW] = a;
    bus.u_wdata[i*DW +: DW] = d;
    bus.u_req[i] = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctl"}, 64'({bus.m_req, bus.m_wr, bus.u_err}), 64'd0);
    chk({tag, "_m_addr"}, bus.m_addr, 64'd0);
    chk({tag, "_m_wdata"}, bus.m_wdata, 64'd0);
    chk({tag, "_u_rdata"}, bus.u_rdata, 64'd0);
    chk({tag, "_u_rdy"}, 64'(bus.u_rdy), 64'd0);
  endtask

  task automatic rand_batch(input logic [NREQ-1:0] mask);
    logic [AW-1:0] a[NREQ];
    logic w[NREQ];
    logic [DW-1:0] d[NREQ];
    logic [NREQ-1:0] pend = mask;
    int exp_idx[$];
    int p = ref_last;
    logic e_err;
    logic [DW-1:0] e_rd;
    cq.delete();
    mq.delete();
    for (int i = 0; i < NREQ; i++) begin
      a[i] = 64'h1000 + 64'($urandom_range(0, 3));
`ifdef MEM_ARBITER_RMW_LOCK_EN
      w[i] = 1'b1;
`else
      w[i] = 1'($urandom_range(0, 1));
`endif
      d[i] = {$urandom, $urandom};
      if (mask[i]) set_req(i, w[i], a[i], d[i]);
    end
    while (pend != 0) begin
      p = (p + 1) % NREQ;
      if (pend[p]) begin
        exp_idx.push_back(p);
        pend[p] = 1'b0;
      end
    end
    ref_last = exp_idx[$];
    wait_cpl(exp_idx.size(), 200);
    tick();
    tick();
    chk("batch_count", 64'(cq.size()), 64'(exp_idx.size()));
    for (int k = 0; k < exp_idx.size() && k < cq.size() && k < mq.size(); k++) begin
      chk("rr_order", 64'(cq[k].idx), 64'(exp_idx[k]));
      chk("rand_m_addr", mq[k].addr, a[exp_idx[k]]);
      chk("rand_m_wr", 64'(mq[k].wr), 64'(w[exp_idx[k]]));
      chk("rand_m_wdata", mq[k].wdata, d[exp_idx[k]]);
      e_err = (mq[k].lat + 1 > TO);
      e_rd = (e_err || w[exp_idx[k]]) ? '0 :
             (shadow.exists(a[exp_idx[k]]) ? shadow[a[exp_idx[k]]] : rd_init(a[exp_idx[k]]));
      if (!e_err && w[exp_idx[k]]) shadow[a[exp_idx[k]]] = d[exp_idx[k]];
      chk("rand_err", 64'(cq[k].err), 64'(e_err));
      chk("rand_rdata", cq[k].rdata, e_rd);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t tv[8];
    int t0;
    int exp_o[3];
    logic [DW-1:0] v;
    bus.u_req = '0;
    bus.u_wr = '0;
    bus.u_addr = '0;
    bus.u_wdata = '0;
    bus.m_rdy = 1'b0;
    bus.m_rdata = '0;
    mem[64'h10] = 64'hDEAD_BEEF_0000_0001;
    tv[0] = '{0, 1'b0, 64'h10, 64'h0, 3, 64'hDEAD_BEEF_0000_0001, 1'b0};
    tv[1] = '{2, 1'b1, 64'h1FFF, 64'h5, 0, 64'h0, 1'b0};
    tv[2] = '{2, 1'b0, 64'h1FFF, 64'h77, 1, 64'h5, 1'b0};
    tv[3] = '{1, 1'b0, 64'h20, 64'h0, 7, 64'h20 ^ K, 1'b0};
    tv[4] = '{3, 1'b0, 64'h30, 64'h1, 99, 64'h0, 1'b1};
    tv[5] = '{1, 1'b1, 64'h40, 64'hABCD, 99, 64'h0, 1'b1};
    tv[6] = '{0, 1'b0, 64'h40, 64'h0, 8, 64'h0, 1'b1};
    tv[7] = '{3, 1'b0, 64'h40, 64'h0, 2, 64'h40 ^ K, 1'b0};
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b1;
    tick();

    fix_lat = 1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 64'h200 + 64'(i), 64'h0);
    rereq = 1;
    wait_cpl(5, 200);
    rereq = 0;
    for (int t = 0; t < 200 && bus.u_req != 0; t++) tick();
    tick();
    tick();
    chk("contention_count", 64'(cq.size()), 64'd8);
    for (int k = 0; k < cq.size(); k++) chk("contention_order", 64'(cq[k].idx), 64'(k % NREQ));

    cq.delete();
    mq.delete();
    fix_lat = 99;
    set_req(2, 1'b0, 64'h300, 64'h0);
    for (int t = 0; t < 10 && !bus.m_req; t++) tick();
    tick();
    tick();
    chk("pre_reset_m_req", 64'(bus.m_req), 64'd1);
    #2 rst = 1'b0;
    #1 chk_reset_outputs("mid_busy_reset");
    bus.u_req = '0;
    tick();
    tick();
    rst = 1'b1;
    ref_last = NREQ - 1;
    rand_lat = 1;
    rand_batch('1);
    rand_lat = 0;

    scramble = 1;
    foreach (tv[k]) begin
      cq.delete();
      mq.delete();
      fix_lat = tv[k].lat;
      set_req(tv[k].idx, tv[k].wr, tv[k].addr, tv[k].wdata);
      t0 = cyc;
      wait_cpl(1, 40);
      tick();
      tick();
      chk($sformatf("tv%0d_count", k), 64'(cq.size()), 64'd1);
      if (cq.size() > 0 && mq.size() > 0) begin
        chk($sformatf("tv%0d_idx", k), 64'(cq[0].idx), 64'(tv[k].idx));
        chk($sformatf("tv%0d_rdata", k), cq[0].rdata, tv[k].rdata);
        chk($sformatf("tv%0d_err", k), 64'(cq[0].err), 64'(tv[k].err));
        chk($sformatf("tv%0d_latency", k), 64'(cq[0].cyc - t0), 64'(tv[k].err ? TO + 1 : tv[k].lat + 2));
        chk($sformatf("tv%0d_m_addr", k), mq[0].addr, tv[k].addr);
        chk($sformatf("tv%0d_m_wr", k), 64'(mq[0].wr), 64'(tv[k].wr));
        chk($sformatf("tv%0d_m_wdata", k), mq[0].wdata, tv[k].wdata);
      end
      ref_last = tv[k].idx;
    end
    scramble = 0;

    cq.delete();
    mq.delete();
    spur = 1;
    fix_lat = 99;
    tick();
    set_req(1, 1'b0, 64'h50, 64'h0);
    wait_cpl(1, 40);
    repeat (5) tick();
    chk("spurious_count", 64'(cq.size()), 64'd1);
    chk("spurious_m_req", 64'(bus.m_req), 64'd0);
    if (cq.size() > 0) begin
      chk("timeout_err", 64'(cq[0].err), 64'd1);
      chk("timeout_rdata", cq[0].rdata, 64'd0);
    end
    spur = 0;
    ref_last = 1;
    tick();

    rand_lat = 1;
    for (int b = 0; b < 30; b++) rand_batch(NREQ'($urandom_range(1, (1 << NREQ) - 1)));
    rand_lat = 0;

    cq.delete();
    mq.delete();
    fix_lat = 1;
    set_req(0, 1'b0, 64'h60, 64'h0);
    wait_cpl(1, 40);
    v = cq.size() > 0 ? cq[0].rdata : '0;
    chk("lock_read", v, rd_init(64'h60));
    set_req(1, 1'b1, 64'h70, 64'h1);
    tick();
    set_req(0, 1'b1, 64'h60, v + 1);
    wait_cpl(3, 80);
`ifdef MEM_ARBITER_RMW_LOCK_EN
    exp_o = '{0, 0, 1};
`else
    exp_o = '{0, 1, 0};
`endif
    for (int k = 0; k < 3 && k < cq.size(); k++) chk("lock_order", 64'(cq[k].idx), 64'(exp_o[k]));
    tick();
    tick();
    cq.delete();
    set_req(2, 1'b0, 64'h60, 64'h0);
    wait_cpl(1, 40);
    if (cq.size() > 0) chk("rmw_result", cq[0].rdata, rd_init(64'h60) + 1);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
